// File: rtl/fetch_sequencer_pkg.sv
// Shared constants for the 4-bit processor front end: phase encoding,
// decoder-address field layout and control-word bit positions.
package fetch_sequencer_pkg;

    localparam int          PC_W_DEFAULT     = 12;
    localparam logic [11:0] RESET_PC_DEFAULT = 12'h000;

    localparam logic PHASE_FETCH = 1'b0;
    localparam logic PHASE_EXEC  = 1'b1;

    // decode_addr = {instr, C, Z, phase}
    localparam int DA_W        = 7;
    localparam int DA_INSTR_HI = 6;
    localparam int DA_INSTR_LO = 3;
    localparam int DA_C        = 2;
    localparam int DA_Z        = 1;
    localparam int DA_PHASE    = 0;

    // Bit positions of the sequencer controls inside the 13-bit decoder word
    localparam int CW_W          = 13;
    localparam int CW_INC_PC     = 0;
    localparam int CW_LOAD_PC    = 1;
    localparam int CW_LOAD_FLAGS = 2;

    function automatic logic [DA_W-1:0] pack_decode_addr(
        input logic [3:0] instr_f,
        input logic       c_f,
        input logic       z_f,
        input logic       phase_f
    );
        logic [DA_W-1:0] a;
        a                          = '0;
        a[DA_INSTR_HI:DA_INSTR_LO] = instr_f;
        a[DA_C]                    = c_f;
        a[DA_Z]                    = z_f;
        a[DA_PHASE]                = phase_f;
        return a;
    endfunction

endpackage

// File: rtl/fetch_sequencer_if.sv
// Bus between the fetch sequencer (master) and its ROM/decoder/ALU neighbours (slave).
interface fetch_sequencer_if #(
    parameter int PC_W = 12
);
    logic [7:0]      program_byte;
    logic            inc_pc;
    logic            load_pc;
    logic            load_flags;
    logic            alu_c;
    logic            alu_z;
    logic [PC_W-1:0] pc;
    logic            phase;
    logic [3:0]      instr;
    logic [3:0]      oprnd;
    logic            c_flag;
    logic            z_flag;
    logic [6:0]      decode_addr;
    logic [PC_W-1:0] ram_addr;

    modport master (
        input  program_byte, inc_pc, load_pc, load_flags, alu_c, alu_z,
        output pc, phase, instr, oprnd, c_flag, z_flag, decode_addr, ram_addr
    );

    modport slave (
        output program_byte, inc_pc, load_pc, load_flags, alu_c, alu_z,
        input  pc, phase, instr, oprnd, c_flag, z_flag, decode_addr, ram_addr
    );
endinterface

// File: rtl/fetch_sequencer_en_reg.sv
// Parameterised-width register with synchronous active-high reset and load enable.
module en_reg #(
    parameter int           W       = 8,
    parameter logic [W-1:0] RST_VAL = '0
) (
    input  logic         CLK,
    input  logic         RST,
    input  logic         en,
    input  logic [W-1:0] d,
    output logic [W-1:0] q
);

    // NOTE: sequential state is written with <= so every register samples
    // pre-edge values regardless of block ordering.
    always_ff @(posedge CLK) begin
        if (RST)
            q <= RST_VAL;
        else if (en)
            q <= d;
    end

endmodule

// File: rtl/fetch_sequencer.sv
// Program counter, two-phase fetch/execute sequencer, fetch register and
// C/Z flags for the 4-bit processor; feeds the instruction decoder.
module fetch_sequencer
    import fetch_sequencer_pkg::*;
#(
    parameter int              PC_W     = PC_W_DEFAULT,
    parameter logic [PC_W-1:0] RESET_PC = RESET_PC_DEFAULT
) (
    input  logic               CLK,
    input  logic               RST,
    input  logic               ENABLE,
    fetch_sequencer_if.master  bus
);

    logic            phase;
    logic [PC_W-1:0] pc;
    logic [PC_W-1:0] pc_next;
    logic [3:0]      instr;
    logic [3:0]      oprnd;
    logic            c_flag;
    logic            z_flag;
    logic [PC_W-1:0] ram_addr;

    wire fetch_en = ENABLE && (phase == PHASE_FETCH);
    wire flags_en = ENABLE && (phase == PHASE_EXEC) && bus.load_flags;

    assign ram_addr = PC_W'({oprnd, bus.program_byte});

    // NOTE: pc_next takes a default before any branch so no path leaves it
    // unassigned and no latch is inferred.
    always_comb begin
        pc_next = pc;
        if (bus.load_pc && phase == PHASE_EXEC)
            pc_next = ram_addr;
        else if (bus.inc_pc)
            pc_next = pc + PC_W'(1);
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            pc    <= RESET_PC;
            phase <= PHASE_FETCH;
        end else if (ENABLE) begin
            pc    <= pc_next;
            phase <= ~phase;
        end
    end

    en_reg #(.W(8)) u_fetch_reg (
        .CLK (CLK),
        .RST (RST),
        .en  (fetch_en),
        .d   (bus.program_byte),
        .q   ({instr, oprnd})
    );

    en_reg #(.W(2)) u_flags_reg (
        .CLK (CLK),
        .RST (RST),
        .en  (flags_en),
        .d   ({bus.alu_c, bus.alu_z}),
        .q   ({c_flag, z_flag})
    );

    assign bus.pc          = pc;
    assign bus.phase       = phase;
    assign bus.instr       = instr;
    assign bus.oprnd       = oprnd;
    assign bus.c_flag      = c_flag;
    assign bus.z_flag      = z_flag;
    assign bus.ram_addr    = ram_addr;
    assign bus.decode_addr = pack_decode_addr(instr, c_flag, z_flag, phase);

endmodule

// File: tb/tb_fetch_sequencer.sv
// Directed-vector bench for fetch_sequencer with hand-computed expectations.
module tb_fetch_sequencer;

    logic CLK = 1'b0;
    logic RST;
    logic ENABLE;

    int n_compared   = 0;
    int n_mismatched = 0;

    fetch_sequencer_if #(.PC_W(12)) bus ();

    fetch_sequencer #(.PC_W(12), .RESET_PC(12'h000)) dut (
        .CLK    (CLK),
        .RST    (RST),
        .ENABLE (ENABLE),
        .bus    (bus)
    );

    always #5 CLK = ~CLK;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_compared++;
        if (got !== exp) begin
            n_mismatched++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Advance one rising edge, then settle before sampling/driving.
    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    task automatic drive(input logic [7:0] pb, input logic inc, input logic ld,
                         input logic lf, input logic c, input logic z);
        bus.program_byte = pb;
        bus.inc_pc       = inc;
        bus.load_pc      = ld;
        bus.load_flags   = lf;
        bus.alu_c        = c;
        bus.alu_z        = z;
    endtask

    task automatic check_state(input string tag, input logic [11:0] pc, input logic ph,
                               input logic [3:0] ins, input logic [3:0] op,
                               input logic [1:0] fl);
        check({tag, ".pc"},    32'(bus.pc), 32'(pc));
        check({tag, ".phase"}, 32'(bus.phase), 32'(ph));
        check({tag, ".instr"}, 32'(bus.instr), 32'(ins));
        check({tag, ".oprnd"}, 32'(bus.oprnd), 32'(op));
        check({tag, ".flags"}, 32'({bus.c_flag, bus.z_flag}), 32'(fl));
    endtask

    initial begin
        RST    = 1'b1;
        ENABLE = 1'b1;
        drive(8'h00, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);

        // 1. Reset then run
        step();
        step();
        check_state("rst", 12'h000, 1'b0, 4'h0, 4'h0, 2'b00);
        check("rst.decode_addr", 32'(bus.decode_addr), 32'h00);
        RST = 1'b0;
        step(); check_state("run1", 12'h001, 1'b1, 4'h0, 4'h0, 2'b00);
        step(); check_state("run2", 12'h002, 1'b0, 4'h0, 4'h0, 2'b00);
        step(); check_state("run3", 12'h003, 1'b1, 4'h0, 4'h0, 2'b00);
        step(); check_state("run4", 12'h004, 1'b0, 4'h0, 4'h0, 2'b00);

        // 2. Fetch latch
        drive(8'h5A, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        step(); check_state("fetch", 12'h005, 1'b1, 4'h5, 4'hA, 2'b00);
        drive(8'h3C, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        #1;
        check("fetch.ram_addr", 32'(bus.ram_addr), 32'hA3C);
        check("fetch.decode_addr", 32'(bus.decode_addr), 32'h29);
        step(); check_state("exec", 12'h006, 1'b0, 4'h5, 4'hA, 2'b00);

        // 3. Jump: load_pc in FETCH is ignored, increment applies
        drive(8'hC7, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
        step(); check_state("jmp.f", 12'h007, 1'b1, 4'hC, 4'h7, 2'b00);
        drive(8'h21, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        #1;
        check("jmp.ram_addr", 32'(bus.ram_addr), 32'h721);
        step(); check_state("jmp.e", 12'h721, 1'b0, 4'hC, 4'h7, 2'b00);
        drive(8'hC7, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        step(); check("jmp2.f.pc", 32'(bus.pc), 32'h722);
        drive(8'h21, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
        step(); check_state("jmp2.e", 12'h721, 1'b0, 4'hC, 4'h7, 2'b00);

        // 4. Flags gating
        drive(8'h90, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1);
        step(); check_state("flg.f", 12'h722, 1'b1, 4'h9, 4'h0, 2'b00);
        drive(8'h00, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1);
        step(); check_state("flg.e", 12'h723, 1'b0, 4'h9, 4'h0, 2'b11);
        check("flg.da_cz", 32'(bus.decode_addr[2:1]), 32'h3);
        check("flg.da_ph", 32'(bus.decode_addr[0]), 32'h0);
        check("flg.decode_addr", 32'(bus.decode_addr), 32'h4E);

        // 5. Wrap: jump to FFF, then increment
        drive(8'hFF, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        step(); check_state("wrap.f", 12'h724, 1'b1, 4'hF, 4'hF, 2'b11);
        drive(8'hFF, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        step(); check("wrap.jmp.pc", 32'(bus.pc), 32'hFFF);
        drive(8'h12, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        step(); check_state("wrap", 12'h000, 1'b1, 4'h1, 4'h2, 2'b11);

        // 5. Hold with ENABLE=0 while inputs churn
        ENABLE = 1'b0;
        drive(8'hA5, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
        step(); check_state("hold1", 12'h000, 1'b1, 4'h1, 4'h2, 2'b11);
        drive(8'h3E, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0);
        step(); check_state("hold2", 12'h000, 1'b1, 4'h1, 4'h2, 2'b11);
        drive(8'hC4, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1);
        step(); check_state("hold3", 12'h000, 1'b1, 4'h1, 4'h2, 2'b11);
        ENABLE = 1'b1;

        // 6. Reset mid-EXEC discards pending jump and flag capture
        check("rstx.pre_phase", 32'(bus.phase), 32'h1);
        RST = 1'b1;
        drive(8'h55, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0);
        step(); check_state("rstx", 12'h000, 1'b0, 4'h0, 4'h0, 2'b00);
        RST = 1'b0;
        drive(8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        step();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
        $finish;
    end

endmodule
